instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Upstream neighbour of the single-cycle main controller in the RISC-V core. It owns the program counter, fetches each instruction from instruction memory over a req/ack handshake, and holds it in an instruction register. While the register is valid it presents `opc`/`f3` to the controller, then applies the controller's `PC_src`/`is_jalr` decision to form the next PC. It also traps misaligned targets and counts retired instructions.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `imem_req`  out  1  fetch request; held high with `imem_addr` stable until ack.
- `imem_addr`  out  32  byte address of the fetch; always equals `PC`.
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction register.
- `opc`  out  7  `instr[6:0]`, to the controller.
- `f3`  out  3  `instr[14:12]`, to the controller.
- `instr_valid`  out  1  high while in EXEC; the controller and datapath act on `instr`.
- `PC`  out  32  current PC.
- `PC_plus4`  out  32  `PC + 4`, for jal/jalr writeback.
- `PC_src`  in  1  take branch/jump; sampled on commit only.
- `is_jalr`  in  1  jalr target select; sampled on commit only.
- `imm_ext`  in  32  sign-extended immediate for the PC-relative target.
- `alu_result`  in  32  rs1+imm for the jalr target.
- `stall`  in  1  hold EXEC (for example, a multi-cycle data memory access).
- `commit`  out  1  `instr_valid & ~stall`; PC updates at this edge.
- `misaligned`  out  1  sticky trap flag.
- `retire_count`  out  32  number of committed instructions; wraps modulo 2^32.

## Operation
The block is a four-state FSM: IDLE, FETCH, EXEC, TRAP.

- **IDLE:** the reset state. Moves to FETCH unconditionally on the next edge.
- **FETCH:** `imem_req`=1.
  - On an edge where `imem_ack`=1: `instr` <= `imem_rdata`, move to EXEC.
  - Otherwise stay in FETCH.
- **EXEC:** `instr_valid`=1.
  - If `stall`=1: stay in EXEC; PC, `instr` and `retire_count` hold.
  - If `stall`=0 (commit): `retire_count` increments. `next_pc` is selected as follows:
    - `PC_src`=0: `PC+4`.
    - `PC_src`=1, `is_jalr`=0: `PC+imm_ext`.
    - `PC_src`=1, `is_jalr`=1: `{alu_result[31:1],1'b0}`.
  - If `next_pc[1:0]`≠0: PC holds its old value, `misaligned` is set to 1, move to TRAP.
  - Otherwise: PC <= `next_pc`, move to FETCH.
- **TRAP:** no requests and `instr_valid`=0. The only exit is reset.

Arithmetic and input handling:
- All adds are 32-bit and wrap modulo 2^32; carry is discarded.
- `imem_ack` is ignored outside FETCH.
- `PC_src`, `is_jalr`, `imm_ext` and `alu_result` are ignored unless `commit`=1.

## Timing
Reset values, asynchronously while `rst`=0:
- state=IDLE, `PC`=`RESET_PC`, `instr`=32'h0000_0013 (nop).
- `misaligned`=0, `retire_count`=0.
- `imem_req`=0, `instr_valid`=0, `commit`=0.

Output timing:
- `imem_req`, `instr_valid`, `commit`, `opc`, `f3`, `PC_plus4` are combinational from registered state and inputs. There are no other combinational paths.

Cycle-level behaviour:
- First `imem_req` appears in the second cycle after `rst` deasserts (the first cycle is spent in IDLE).
- Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction. Each additional wait cycle adds 1.
- A `stall` of N cycles adds N cycles.
- Ack and a state change on the same edge: `instr` is captured at that edge and `instr_valid` rises in the next cycle.
- Reset mid-operation, including mid-FETCH with a pending ack: state aborts to IDLE immediately. Any ack arriving during or after reset is dropped until FETCH is re-entered.
- `retire_count` wraps from 32'hFFFF_FFFF to 0 on commit with no flag.
- The misaligned commit does not increment `retire_count`.

## Test plan
- **Reset and first fetch:** RESET_PC=0x100, release `rst`, ack in the first FETCH cycle with 0x00500093 -> `imem_req` high in cycle 2, `imem_addr`=0x100; `instr_valid` in cycle 3 with `opc`=0x13, `f3`=0; after commit `PC`=0x104, `retire_count`=1.
- **Wait states and stall:** hold ack low for 3 FETCH cycles, then assert `stall` for 2 EXEC cycles -> `imem_addr` stable throughout, a single `instr` capture, exactly one `commit` pulse, 7 cycles total from FETCH entry to the next FETCH.
- **Taken branch and jalr:**
  - Branch: `PC`=0x200, `PC_src`=1, `is_jalr`=0, `imm_ext`=0xFFFF_FFF8 -> next `PC`=0x1F8.
  - jalr: `is_jalr`=1, `alu_result`=0x307 -> next `PC`=0x306, which is misaligned, so `misaligned`=1, state TRAP, `imem_req` stays 0, `PC` holds 0x1F8.
- **Aligned jalr:** `alu_result`=0x305 -> `PC`=0x304, no trap.
- **Reset mid-fetch:** assert `rst` low while in FETCH and drive ack in the same cycle -> `PC`=RESET_PC, `instr`=0x13, ack ignored; the sequence restarts from IDLE.
- **Counter wrap:** force `retire_count` to 0xFFFF_FFFF via a long run or a backdoor, then commit once -> `retire_count`=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake into an
// instruction register, applies branch/jump decisions and traps misaligned targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opc,
    output logic [2:0]  f3,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    input  logic        PC_src,
    input  logic        is_jalr,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    input  logic        stall,
    output logic        commit,
    output logic        misaligned,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic        commit_s;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    assign pc_plus4_s   = pc_q + 32'd4;
    assign commit_s     = (state_q == ST_EXEC) && !stall;

    assign imem_req     = (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign opc          = instr_q[6:0];
    assign f3           = instr_q[14:12];
    assign instr_valid  = (state_q == ST_EXEC);
    assign PC           = pc_q;
    assign PC_plus4     = pc_plus4_s;
    assign commit       = commit_s;
    assign misaligned   = misaligned_q;
    assign retire_count = retire_count_q;

    // Next-PC candidate; jalr clears bit 0 of the ALU result before the alignment check
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (PC_src) begin
            if (is_jalr) begin
                next_pc_s = alu_result & 32'hFFFF_FFFE;
            end else begin
                next_pc_s = pc_q + imm_ext;
            end
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // FSM next-state and architectural register updates
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        misaligned_d   = misaligned_q;
        retire_count_d = retire_count_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (commit_s) begin
                    if (word_aligned(next_pc_s)) begin
                        pc_d           = next_pc_s;
                        retire_count_d = retire_count_q + 32'd1;
                        state_d        = ST_FETCH;
                    end else begin
                        // Faulting instruction does not retire and the PC stays on it
                        misaligned_d = 1'b1;
                        state_d      = ST_TRAP;
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            instr_q        <= NOP_INSTR;
            misaligned_q   <= 1'b0;
            retire_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            misaligned_q   <= misaligned_d;
            retire_count_q <= retire_count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a phase-level behavioural model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_TRAP  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        PC_src;
    logic        is_jalr;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        stall;
    logic        commit;
    logic        misaligned;
    logic [31:0] retire_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int commits_seen = 0;

    int          m_ph = PH_IDLE;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instr = 32'h0000_0013;
    logic [31:0] m_cnt = 32'd0;
    logic        m_mis = 1'b0;
    logic [31:0] cnt_bias = 32'd0;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opc(opc), .f3(f3), .instr_valid(instr_valid),
        .PC(PC), .PC_plus4(PC_plus4),
        .PC_src(PC_src), .is_jalr(is_jalr), .imm_ext(imm_ext), .alu_result(alu_result),
        .stall(stall), .commit(commit), .misaligned(misaligned), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] next_target(input logic [31:0] pc, input logic src,
                                                input logic jalr, input logic [31:0] imm,
                                                input logic [31:0] alu);
        if (!src)
            return pc + 32'd4;
        else if (!jalr)
            return pc + imm;
        else
            return {alu[31:1], 1'b0};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one step of the fetch/execute rules per clock edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph    <= PH_IDLE;
            m_pc    <= RST_PC;
            m_instr <= 32'h0000_0013;
            m_cnt   <= 32'd0;
            m_mis   <= 1'b0;
        end else if (m_ph == PH_IDLE) begin
            m_ph <= PH_FETCH;
        end else if (m_ph == PH_FETCH) begin
            if (imem_ack) begin
                m_instr <= imem_rdata;
                m_ph    <= PH_EXEC;
            end
        end else if (m_ph == PH_EXEC && !stall) begin
            if ((next_target(m_pc, PC_src, is_jalr, imm_ext, alu_result) & 32'h3) != 32'd0) begin
                m_mis <= 1'b1;
                m_ph  <= PH_TRAP;
            end else begin
                m_pc  <= next_target(m_pc, PC_src, is_jalr, imm_ext, alu_result);
                m_cnt <= m_cnt + 32'd1;
                m_ph  <= PH_FETCH;
            end
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        chk("imem_req",     32'(imem_req),     32'(m_ph == PH_FETCH));
        chk("imem_addr",    imem_addr,         m_pc);
        chk("instr",        instr,             m_instr);
        chk("opc",          32'(opc),          32'(m_instr[6:0]));
        chk("f3",           32'(f3),           32'(m_instr[14:12]));
        chk("instr_valid",  32'(instr_valid),  32'(m_ph == PH_EXEC));
        chk("PC",           PC,                m_pc);
        chk("PC_plus4",     PC_plus4,          m_pc + 32'd4);
        chk("commit",       32'(commit),       32'((m_ph == PH_EXEC) && !stall));
        chk("misaligned",   32'(misaligned),   32'(m_mis));
        chk("retire_count", retire_count,      m_cnt + cnt_bias);
        if (commit)
            commits_seen <= commits_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k0;
        imem_ack = 1'b0; imem_rdata = 32'd0; PC_src = 1'b0; is_jalr = 1'b0;
        imm_ext = 32'd0; alu_result = 32'd0; stall = 1'b0;
        #1 rst = 1'b0;
        tick(); tick();
        #1;
        chk("lit_rst_pc", PC, 32'h0000_0100);
        chk("lit_rst_instr", instr, 32'h0000_0013);
        chk("lit_rst_cnt", retire_count, 32'd0);

        // Reset and first fetch: one IDLE cycle, then a zero-wait fetch
        rst = 1'b1;
        #1;
        chk("lit_idle_req", 32'(imem_req), 32'd0);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        #1;
        chk("lit_first_req", 32'(imem_req), 32'd1);
        chk("lit_first_addr", imem_addr, 32'h0000_0100);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("lit_first_valid", 32'(instr_valid), 32'd1);
        chk("lit_first_opc", 32'(opc), 32'h13);
        chk("lit_first_f3", 32'(f3), 32'd0);
        chk("lit_first_commit", 32'(commit), 32'd1);
        tick();
        #1;
        chk("lit_first_pc", PC, 32'h0000_0104);
        chk("lit_first_cnt", retire_count, 32'd1);

        // Three wait states, then a two-cycle stall: seven cycles FETCH to FETCH
        c0 = cyc; k0 = commits_seen;
        tick(); tick(); tick();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0063;
        #1;
        chk("lit_wait_addr", imem_addr, 32'h0000_0104);
        tick();
        imem_ack = 1'b0; stall = 1'b1;
        #1;
        chk("lit_stall_commit", 32'(commit), 32'd0);
        tick();
        tick();
        stall = 1'b0;
        tick();
        #1;
        chk("lit_wait_cycles", 32'(cyc - c0), 32'd7);
        chk("lit_wait_commits", 32'(commits_seen - k0), 32'd1);
        chk("lit_wait_pc", PC, 32'h0000_0108);

        // Aligned jalr: 0x305 -> 0x304
        imem_ack = 1'b1; imem_rdata = 32'h0000_8067;
        tick();
        imem_ack = 1'b0; PC_src = 1'b1; is_jalr = 1'b1; alu_result = 32'h0000_0305;
        tick();
        #1;
        chk("lit_jalr_pc", PC, 32'h0000_0304);
        chk("lit_jalr_mis", 32'(misaligned), 32'd0);

        // Counter wrap via backdoor during a stall, then jalr to 0x200
        imem_ack = 1'b1; imem_rdata = 32'h0000_8067;
        tick();
        imem_ack = 1'b0; stall = 1'b1; alu_result = 32'h0000_0201;
        cnt_bias = 32'hFFFF_FFFF - m_cnt;
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1 release dut.retire_count_q;
        #1;
        chk("lit_wrap_pre", retire_count, 32'hFFFF_FFFF);
        tick();
        stall = 1'b0;
        tick();
        #1;
        chk("lit_wrap_cnt", retire_count, 32'd0);
        chk("lit_wrap_pc", PC, 32'h0000_0200);

        // Backward branch: 0x200 + (-8) -> 0x1F8
        imem_ack = 1'b1; imem_rdata = 32'hFE00_0CE3;
        tick();
        imem_ack = 1'b0; is_jalr = 1'b0; imm_ext = 32'hFFFF_FFF8;
        tick();
        #1;
        chk("lit_branch_pc", PC, 32'h0000_01F8);

        // Misaligned jalr target 0x306 traps; PC holds, requests stop
        imem_ack = 1'b1; imem_rdata = 32'h0000_8067;
        tick();
        imem_ack = 1'b0; is_jalr = 1'b1; alu_result = 32'h0000_0307;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        #1;
        chk("lit_trap_mis", 32'(misaligned), 32'd1);
        chk("lit_trap_pc", PC, 32'h0000_01F8);
        chk("lit_trap_req", 32'(imem_req), 32'd0);
        chk("lit_trap_valid", 32'(instr_valid), 32'd0);
        chk("lit_trap_cnt", retire_count, 32'd1);
        tick(); tick();
        #1;
        chk("lit_trap_hold", instr, 32'h0000_8067);

        // Reset out of TRAP, then reset again mid-FETCH with an ack present
        imem_ack = 1'b0; PC_src = 1'b0; is_jalr = 1'b0;
        rst = 1'b0; cnt_bias = 32'd0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lit_rstf_pc", PC, 32'h0000_0100);
        chk("lit_rstf_instr", instr, 32'h0000_0013);
        chk("lit_rstf_req", 32'(imem_req), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("lit_rstf_idle", 32'(imem_req), 32'd0);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("lit_rstf_refetch", 32'(imem_req), 32'd1);
        chk("lit_rstf_keep", instr, 32'h0000_0013);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0010_0113;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("lit_rstf_capture", instr, 32'h0010_0113);
        tick();
        #1;
        chk("lit_rstf_pc2", PC, 32'h0000_0104);
        chk("lit_rstf_cnt", retire_count, 32'd1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
